pat_gen: RTL

Serial pattern generator: the transmit side of the team's serial pattern-detection path. On a start request it captures a parallel pattern and a repeat count, then shifts the pattern out MSB-first, one bit per clock, for the requested number of repetitions. An optional idle gap separates repetitions. Its serial output `o` is meant to drive the `i` input of a Moore sequence detector. With the default pattern 5'b10110 it produces the exact sequence such a detector recognises.

---
 rtl/pat_gen.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/pat_gen.sv
// Serial pattern generator: captures a parallel pattern and a repeat count on start, then
// shifts the pattern out MSB-first for the requested repetitions, with optional idle gaps.
module pat_gen #(
    parameter int unsigned PAT_W   = 5,
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned GAP_LEN = 0
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [CNT_W-1:0] rep,
    output logic             o,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int unsigned GAP_W = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;

    localparam logic [BIT_W-1:0] BitLast = BIT_W'(PAT_W - 1);
    localparam logic [GAP_W-1:0] GapLast = GAP_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
    localparam logic [CNT_W-1:0] RemOne  = CNT_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StGap,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   shift_q, shift_d;
    logic [PAT_W-1:0]   pat_q,   pat_d;
    logic [CNT_W-1:0]   rem_q,   rem_d;
    logic [BIT_W-1:0]   bit_q,   bit_d;
    logic [GAP_W-1:0]   gap_q,   gap_d;

    logic o_q,     o_d;
    logic valid_q, valid_d;
    logic busy_q,  busy_d;
    logic done_q,  done_d;

    // State register; outputs are registered alongside the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q <= StIdle;
            shift_q <= '0;
            pat_q   <= '0;
            rem_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            o_q     <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            pat_q   <= pat_d;
            rem_q   <= rem_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            o_q     <= o_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        pat_d   = pat_q;
        rem_d   = rem_q;
        bit_d   = bit_q;
        gap_d   = gap_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (rep != '0) begin
                        pat_d   = pat_in;
                        shift_d = pat_in;
                        rem_d   = rep;
                        bit_d   = '0;
                        state_d = StShift;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StShift: begin
                shift_d = {shift_q[PAT_W-2:0], 1'b0};
                bit_d   = bit_q + 1'b1;
                if (bit_q == BitLast) begin
                    rem_d = rem_q - 1'b1;
                    bit_d = '0;
                    if (rem_q == RemOne) begin
                        state_d = StDone;
                    end else begin
                        // Next repetition comes from the captured copy, never from live pat_in.
                        shift_d = pat_q;
                        if (GAP_LEN != 0) begin
                            gap_d   = '0;
                            state_d = StGap;
                        end
                    end
                end
            end
            StGap: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GapLast) begin
                    state_d = StShift;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Decode from the next state so the registered outputs line up with state_q.
    always_comb begin
        o_d     = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_d)
            StShift: begin
                o_d     = shift_d[PAT_W-1];
                valid_d = 1'b1;
                busy_d  = 1'b1;
            end
            StGap: begin
                busy_d = 1'b1;
            end
            StDone: begin
                done_d = 1'b1;
            end
            default: begin
                o_d = 1'b0;
            end
        endcase
    end

    assign o     = o_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

    a_o_needs_valid: assert property (@(posedge clk) disable iff (!rst_b) o |-> valid);
    a_valid_busy:    assert property (@(posedge clk) disable iff (!rst_b) valid |-> busy);
    a_done_alone:    assert property (@(posedge clk) disable iff (!rst_b) done |-> !busy);
    a_done_pulse:    assert property (@(posedge clk) disable iff (!rst_b) done |=> !done);

endmodule
